// File: rtl/onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port 1-cycle-latency on-chip RAM.
// Define ARB_B_PRIORITY_EN to give port B strict priority with a bounded A starvation window.
module onchip_memory_arbiter #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [ADDR_W-1:0]     i_a_address,
  input  logic [DATA_W/8-1:0]   i_a_byteenable,
  input  logic                  i_a_read,
  input  logic                  i_a_write,
  input  logic [DATA_W-1:0]     i_a_writedata,
  output logic                  o_a_waitrequest,
  output logic [DATA_W-1:0]     o_a_readdata,
  output logic                  o_a_readdatavalid,
  input  logic [ADDR_W-1:0]     i_b_address,
  input  logic [DATA_W/8-1:0]   i_b_byteenable,
  input  logic                  i_b_read,
  input  logic                  i_b_write,
  input  logic [DATA_W-1:0]     i_b_writedata,
  output logic                  o_b_waitrequest,
  output logic [DATA_W-1:0]     o_b_readdata,
  output logic                  o_b_readdatavalid,
  output logic [ADDR_W-1:0]     o_mem_address,
  output logic [DATA_W/8-1:0]   o_mem_byteenable,
  output logic                  o_mem_chipselect,
  output logic                  o_mem_write,
  output logic [DATA_W-1:0]     o_mem_writedata,
  output logic                  o_mem_clken,
  input  logic [DATA_W-1:0]     i_mem_readdata
);

  localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_burst_cnt, w_burst_cnt_d, w_cnt_inc;
  logic       r_last_b, w_last_b_d;
  logic       r_rd_pend, r_rd_owner_b;
  logic       w_req_a, w_req_b, w_gnt_a, w_gnt_b, w_rd_acc;

  assign w_req_a = i_a_read | i_a_write;
  assign w_req_b = i_b_read | i_b_write;

  always_comb begin
    w_gnt_a       = 1'b0;
    w_gnt_b       = 1'b0;
    w_burst_cnt_d = 8'd0;
    // Counter holds (grants to current owner - 1), capped at the switch point
    w_cnt_inc     = (r_burst_cnt >= BurstLast) ? BurstLast : r_burst_cnt + 8'd1;
    if (w_req_a && w_req_b) begin
`ifdef ARB_B_PRIORITY_EN
      if (r_state == StOwnB && r_burst_cnt >= BurstLast) begin
        w_gnt_a = 1'b1;
      end else begin
        w_gnt_b = 1'b1;
        if (r_state == StOwnB) w_burst_cnt_d = w_cnt_inc;
      end
`else
      if (r_state == StOwnA) begin
        if (r_burst_cnt >= BurstLast) begin
          w_gnt_b = 1'b1;
        end else begin
          w_gnt_a       = 1'b1;
          w_burst_cnt_d = w_cnt_inc;
        end
      end else if (r_state == StOwnB) begin
        if (r_burst_cnt >= BurstLast) begin
          w_gnt_a = 1'b1;
        end else begin
          w_gnt_b       = 1'b1;
          w_burst_cnt_d = w_cnt_inc;
        end
      end else if (r_last_b) begin
        w_gnt_a = 1'b1;
      end else begin
        w_gnt_b = 1'b1;
      end
`endif
    end else if (w_req_a) begin
      w_gnt_a = 1'b1;
      if (r_state == StOwnA) w_burst_cnt_d = w_cnt_inc;
    end else if (w_req_b) begin
      w_gnt_b = 1'b1;
      if (r_state == StOwnB) w_burst_cnt_d = w_cnt_inc;
    end
  end

  always_comb begin
    w_state_d  = StIdle;
    w_last_b_d = r_last_b;
    if (w_gnt_a) begin
      w_state_d  = StOwnA;
      w_last_b_d = 1'b0;
    end else if (w_gnt_b) begin
      w_state_d  = StOwnB;
      w_last_b_d = 1'b1;
    end
  end

  // A simultaneous read+write is a write, so it never produces a read return
  assign w_rd_acc = (w_gnt_a & i_a_read & ~i_a_write) | (w_gnt_b & i_b_read & ~i_b_write);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_burst_cnt  <= 8'd0;
      r_last_b     <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_owner_b <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_burst_cnt  <= w_burst_cnt_d;
      r_last_b     <= w_last_b_d;
      r_rd_pend    <= w_rd_acc;
      r_rd_owner_b <= w_gnt_b;
    end
  end

  assign o_a_waitrequest   = w_req_a & ~w_gnt_a;
  assign o_b_waitrequest   = w_req_b & ~w_gnt_b;
  assign o_a_readdata      = i_mem_readdata;
  assign o_b_readdata      = i_mem_readdata;
  assign o_a_readdatavalid = r_rd_pend & ~r_rd_owner_b;
  assign o_b_readdatavalid = r_rd_pend & r_rd_owner_b;

  assign o_mem_address    = w_gnt_b ? i_b_address    : i_a_address;
  assign o_mem_byteenable = w_gnt_b ? i_b_byteenable : i_a_byteenable;
  assign o_mem_writedata  = w_gnt_b ? i_b_writedata  : i_a_writedata;
  assign o_mem_chipselect = w_gnt_a | w_gnt_b;
  assign o_mem_write      = (w_gnt_a & i_a_write) | (w_gnt_b & i_b_write);
  assign o_mem_clken      = 1'b1;

endmodule
